// File: rtl/acc_filter.sv
// -----------------------------------------------------------------------------
// acc_filter
//
// Acceptance filter for received CAN identifiers. Each identifier from the
// receiver is compared against the acceptance code under the acceptance mask.
// The result goes to the receive buffer logic as a one-cycle accept or reject
// pulse. Standard (11-bit) and extended (29-bit) identifiers are both handled.
// A small FSM spreads the compare over one or two cycles. Identifiers that
// arrive while a compare is in progress are dropped, and the sticky overrun
// flag records the loss.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-low
//   id_valid   one-cycle strobe: rx_id / rx_ide valid
//   rx_id      identifier; a standard ID is left-aligned in rx_id[28:18]
//   rx_ide     1 = extended frame, 0 = standard frame
//   filt_en    1 = filtering active, 0 = accept everything
//   acc_code1  acceptance code word 1, compared with rx_id[28:13]
//   acc_code2  acceptance code word 2, bits [15:3] compared with rx_id[12:0]
//   acc_mask1  acceptance mask word 1 (1 = compare, 0 = don't care)
//   acc_mask2  acceptance mask word 2, bits [15:3] used
//   ovr_clr    clears the overrun flag (a coincident new overrun wins)
//   busy       compare in progress; a new id_valid is dropped while high
//   accept     one-cycle pulse: identifier accepted
//   reject     one-cycle pulse: identifier rejected
//   overrun    sticky: an id_valid arrived while busy
//
// Timing: edge E samples id_valid. The verdict pulse is visible after edge
// E+2 when the first word decides. It is visible after edge E+3 when an
// extended frame also needs the second word.
// -----------------------------------------------------------------------------
module acc_filter #(
    parameter int IDW = 29  // CAN extended-ID width; bit slices below assume 29
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           id_valid,
    input  logic [IDW-1:0] rx_id,
    input  logic           rx_ide,
    input  logic           filt_en,
    input  logic [15:0]    acc_code1,
    input  logic [15:0]    acc_code2,
    input  logic [15:0]    acc_mask1,
    input  logic [15:0]    acc_mask2,
    input  logic           ovr_clr,
    output logic           busy,
    output logic           accept,
    output logic           reject,
    output logic           overrun
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMP1   = 2'd1,
        CMP2   = 2'd2,
        RESULT = 2'd3
    } state_e;

    state_e state_q, state_d;

    // Snapshot of the frame and of the filter setup. CPU writes to the code and
    // mask registers after id_valid must not disturb the compare in flight.
    logic [IDW-1:0] id_q;
    logic           ide_q;
    logic           fen_q;
    logic [15:0]    code1_q, mask1_q;
    logic [12:0]    code2_q, mask2_q;

    logic verdict_q, verdict_d;  // 1 = accept, held until the RESULT cycle
    logic accept_q, accept_d;
    logic reject_q, reject_d;
    logic overrun_q, overrun_d;

    logic load;
    logic w1_match;
    logic w2_match;

    // Low bits of code/mask word 2 have no identifier bits behind them.
    logic unused_bits;
    assign unused_bits = ^{acc_code2[2:0], acc_mask2[2:0]};

    // A standard frame compares only the top 11 identifier bits against
    // code1[15:5]. An extended frame compares all 16 bits of word 1.
    assign w1_match = ide_q
        ? (((id_q[28:13] ^ code1_q) & mask1_q) == '0)
        : (((id_q[28:18] ^ code1_q[15:5]) & mask1_q[15:5]) == '0);

    assign w2_match = (((id_q[12:0] ^ code2_q) & mask2_q) == '0);

    // ---------------------------------------------------------------- state reg
    // NOTE: every sequential block uses non-blocking assignments so that all
    // registers update together from values sampled at the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            verdict_q <= 1'b0;
            accept_q  <= 1'b0;
            reject_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            verdict_q <= verdict_d;
            accept_q  <= accept_d;
            reject_q  <= reject_d;
            overrun_q <= overrun_d;
        end
    end

    // NOTE: the snapshot registers are reset along with the control state.
    // They are few and narrow, and a reset value keeps them X-free before
    // the first frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_q    <= '0;
            ide_q   <= 1'b0;
            fen_q   <= 1'b0;
            code1_q <= '0;
            mask1_q <= '0;
            code2_q <= '0;
            mask2_q <= '0;
        end else if (load) begin
            id_q    <= rx_id;
            ide_q   <= rx_ide;
            fen_q   <= filt_en;
            code1_q <= acc_code1;
            mask1_q <= acc_mask1;
            code2_q <= acc_code2[15:3];
            mask2_q <= acc_mask2[15:3];
        end
    end

    // --------------------------------------------------------------- next state
    // NOTE: each signal driven here gets a default first, so that no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        verdict_d = verdict_q;
        unique case (state_q)
            IDLE: begin
                if (id_valid) state_d = CMP1;
            end
            CMP1: begin
                if (!fen_q) begin
                    state_d   = RESULT;
                    verdict_d = 1'b1;
                end else if (!w1_match) begin
                    state_d   = RESULT;
                    verdict_d = 1'b0;
                end else if (!ide_q) begin
                    state_d   = RESULT;
                    verdict_d = 1'b1;
                end else begin
                    state_d   = CMP2;
                end
            end
            CMP2: begin
                state_d   = RESULT;
                verdict_d = w2_match;
            end
            RESULT: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------ outputs
    always_comb begin
        busy     = (state_q != IDLE);
        load     = (state_q == IDLE) && id_valid;
        accept_d = (state_q == RESULT) &&  verdict_q;
        reject_d = (state_q == RESULT) && !verdict_q;
        // An identifier dropped while busy sets the flag even when it
        // coincides with a clear.
        if (id_valid && busy) overrun_d = 1'b1;
        else if (ovr_clr)     overrun_d = 1'b0;
        else                  overrun_d = overrun_q;
    end

    assign accept  = accept_q;
    assign reject  = reject_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_acc_filter.sv
// -----------------------------------------------------------------------------
// tb_acc_filter
//
// Directed test of acc_filter. A timing model at transaction level predicts
// busy/accept/reject/overrun for every clock edge. It works from the filter
// rules and the frame latencies, and one process compares the DUT against it
// after each edge. Each directed frame also checks its verdict and latency
// against hand-computed literals.
// -----------------------------------------------------------------------------
module tb_acc_filter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid = 1'b0;
    logic [28:0] rx_id = '0;
    logic        rx_ide = 1'b0;
    logic        filt_en = 1'b1;
    logic [15:0] acc_code1 = '0;
    logic [15:0] acc_code2 = '0;
    logic [15:0] acc_mask1 = '0;
    logic [15:0] acc_mask2 = '0;
    logic        ovr_clr = 1'b0;
    logic        busy, accept, reject, overrun;

    int checks   = 0;
    int failures = 0;

    acc_filter #(.IDW(29)) dut (
        .clk       (clk),
        .rst       (rst),
        .id_valid  (id_valid),
        .rx_id     (rx_id),
        .rx_ide    (rx_ide),
        .filt_en   (filt_en),
        .acc_code1 (acc_code1),
        .acc_code2 (acc_code2),
        .acc_mask1 (acc_mask1),
        .acc_mask2 (acc_mask2),
        .ovr_clr   (ovr_clr),
        .busy      (busy),
        .accept    (accept),
        .reject    (reject),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------ model
    // Verdict: the identifier is treated as one 29-bit word against a 29-bit
    // code/mask built from both words. Standard frames keep only the top 11
    // mask bits.
    function automatic bit m_accept(input logic [28:0] id, input bit ide, input bit fen,
                                    input logic [15:0] c1, input logic [15:0] c2,
                                    input logic [15:0] m1, input logic [15:0] m2);
        logic [28:0] code, mask;
        code = {c1, c2[15:3]};
        mask = {m1, m2[15:3]};
        if (!ide) mask = mask & {11'h7FF, 18'h0};
        return !fen || (((id ^ code) & mask) == 29'h0);
    endfunction

    // Latency in edges from the sampling edge to the visible pulse. It is 3
    // only when an extended frame passes word 1 with filtering enabled.
    function automatic int m_latency(input logic [28:0] id, input bit ide, input bit fen,
                                     input logic [15:0] c1, input logic [15:0] m1);
        logic [28:0] diff;
        diff = (id ^ {c1, 13'h0}) & {m1, 13'h0};
        return (fen && ide && (diff == 29'h0)) ? 3 : 2;
    endfunction

    int       cyc     = 0;     // edges counted since reset release
    int       st      = -100;  // edge that started the current frame
    int       pend    = -100;  // edge after which its pulse is visible
    int       free_at = 0;     // first edge that may sample a new identifier
    bit       pv      = 1'b0;  // predicted verdict
    bit       m_ovr   = 1'b0;
    logic [3:0] exp_vec = '0;  // {busy, accept, reject, overrun} after this edge

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            st = -100; pend = -100; free_at = 0; m_ovr = 1'b0; exp_vec = '0;
        end else begin
            bit set_o;
            set_o = 1'b0;
            cyc++;
            if (id_valid) begin
                if (cyc >= free_at) begin
                    int lat;
                    lat     = m_latency(rx_id, rx_ide, filt_en, acc_code1, acc_mask1);
                    pv      = m_accept(rx_id, rx_ide, filt_en, acc_code1, acc_code2,
                                       acc_mask1, acc_mask2);
                    st      = cyc;
                    pend    = cyc + lat;
                    free_at = cyc + lat + 1;
                end else begin
                    set_o = 1'b1;
                end
            end
            if (set_o)        m_ovr = 1'b1;
            else if (ovr_clr) m_ovr = 1'b0;
            exp_vec = {(cyc >= st) && (cyc < pend),
                       (cyc == pend) && pv,
                       (cyc == pend) && !pv,
                       m_ovr};
        end
    end

    // Compare process: one check per edge while out of reset.
    always @(posedge clk) begin
        #1;
        if (rst) check("cycle busy/acc/rej/ovr", {28'h0, busy, accept, reject, overrun},
                       {28'h0, exp_vec});
    end

    // ---------------------------------------------------------------- stimulus
    // Present one identifier, then check the verdict and latency against
    // literals. dup re-asserts id_valid in the next cycle (overrun), with
    // optional ovr_clr. wr rewrites code1 one cycle after id_valid.
    task automatic xfer(input string name, input logic [28:0] id, input bit ide, input bit fen,
                        input bit exp_acc, input int exp_lat,
                        input bit dup = 1'b0, input bit clr = 1'b0,
                        input bit wr = 1'b0, input logic [15:0] wr_c1 = 16'h0);
        int lat;
        @(negedge clk);
        rx_id = id; rx_ide = ide; filt_en = fen; id_valid = 1'b1;
        @(negedge clk);
        id_valid = dup; ovr_clr = clr;
        if (wr) acc_code1 = wr_c1;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin id_valid = 1'b0; ovr_clr = 1'b0; end
            if (accept || reject) begin lat = k; break; end
        end
        check({name, " latency"}, lat, exp_lat);
        check({name, " accept"}, {31'h0, accept}, {31'h0, exp_acc});
        check({name, " reject"}, {31'h0, reject}, {31'h0, !exp_acc});
    endtask

    initial begin
        bit seen;
        repeat (2) @(negedge clk);
        check("reset outputs", {28'h0, busy, accept, reject, overrun}, 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Standard frames: code1[15:5] = 0x123.
        acc_code1 = 16'h2460; acc_mask1 = 16'hFFE0;
        xfer("std accept",   {11'h123, 18'h2ABCD}, 1'b0, 1'b1, 1'b1, 2);
        xfer("std reject",   {11'h122, 18'h00000}, 1'b0, 1'b1, 1'b0, 2);
        acc_mask1 = 16'hFFC0;
        xfer("std dontcare", {11'h122, 18'h3FFFF}, 1'b0, 1'b1, 1'b1, 2);

        // Extended frames: word2 compares rx_id[12:0] with code2[15:3] = 0x247.
        acc_code1 = 16'hABCD; acc_mask1 = 16'hFFFF;
        acc_code2 = 16'h1238; acc_mask2 = 16'hFFF8;
        xfer("ext accept",   {16'hABCD, 13'h0247}, 1'b1, 1'b1, 1'b1, 3);
        xfer("ext w2 rej",   {16'hABCD, 13'h0246}, 1'b1, 1'b1, 1'b0, 3);
        xfer("ext w1 rej",   {16'hABCC, 13'h0247}, 1'b1, 1'b1, 1'b0, 2);

        // Filtering disabled accepts anything after the first word.
        xfer("filt off",     29'h0F0F0F0F, 1'b1, 1'b0, 1'b1, 2);

        // Snapshot: a code1 write one cycle after id_valid does not affect it.
        acc_code1 = 16'h2460; acc_mask1 = 16'hFFE0;
        xfer("snapshot old", {11'h123, 18'h0}, 1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b1, 16'h0000);
        xfer("snapshot new", {11'h123, 18'h0}, 1'b0, 1'b1, 1'b0, 2);

        // Both masks zero: every identifier is accepted.
        acc_mask1 = 16'h0000; acc_mask2 = 16'h0000;
        xfer("mask0 ext",    29'h15A5A5A5, 1'b1, 1'b1, 1'b1, 3);
        xfer("mask0 std",    29'h1FFFFFFF, 1'b0, 1'b1, 1'b1, 2);

        // Overrun: the second id_valid is dropped and the first verdict stands.
        acc_code1 = 16'h2460; acc_mask1 = 16'hFFE0;
        xfer("ovr first",    {11'h123, 18'h0}, 1'b0, 1'b1, 1'b1, 2, 1'b1);
        check("overrun set", {31'h0, overrun}, 32'h1);
        repeat (3) @(negedge clk);
        check("overrun sticky", {31'h0, overrun}, 32'h1);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        check("overrun cleared", {31'h0, overrun}, 32'h0);
        xfer("ovr set+clr",  {11'h7FF, 18'h0}, 1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b1);
        check("overrun set wins", {31'h0, overrun}, 32'h1);

        // Asynchronous reset in the middle of CMP2.
        acc_code1 = 16'hABCD; acc_mask1 = 16'hFFFF;
        acc_code2 = 16'h1238; acc_mask2 = 16'hFFF8;
        @(negedge clk);
        rx_id = {16'hABCD, 13'h0247}; rx_ide = 1'b1; filt_en = 1'b1; id_valid = 1'b1;
        @(negedge clk);
        id_valid = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check("async reset", {28'h0, busy, accept, reject, overrun}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (accept || reject) seen = 1'b1;
        end
        check("no pulse after reset", {31'h0, seen}, 32'h0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/acc_filter.md
Name: acc_filter

Overview:
- Consumer side of the acceptance code/mask registers (CPU write path feeds code1/code2 and mask1/mask2).
- Takes each identifier the CAN receiver presents and compares it against the acceptance code under the acceptance mask.
- Emits a one-cycle accept or reject pulse to the receive buffer logic.
- Handles standard (11-bit) and extended (29-bit) identifiers with a small compare FSM; flags identifiers lost while busy.

Parameters:
- IDW, 29, received identifier width (fixed CAN extended-ID width; not meant to be changed)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low
- id_valid  in  1  one-cycle strobe from receiver: rx_id/rx_ide valid
- rx_id  in  29  identifier; standard ID left-aligned in rx_id[28:18], rx_id[17:0] ignored when rx_ide=0
- rx_ide  in  1  1 = extended frame, 0 = standard frame
- filt_en  in  1  1 = filtering active, 0 = accept all
- acc_code1  in  16  acceptance code word 1 (address 10000 side)
- acc_code2  in  16  acceptance code word 2
- acc_mask1  in  16  acceptance mask word 1; bit=1 compare, bit=0 don't care
- acc_mask2  in  16  acceptance mask word 2
- ovr_clr  in  1  clears overrun flag
- busy  out  1  compare in progress
- accept  out  1  one-cycle pulse: identifier accepted
- reject  out  1  one-cycle pulse: identifier rejected
- overrun  out  1  sticky: id_valid arrived while busy

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE; busy, accept, reject and overrun = 0; snapshot registers = 0.
- Bit mapping, word1: rx_id[28:13] vs code1[15:0].
- Bit mapping, word2: rx_id[12:0] vs code2[15:3]; code2[2:0] and mask2[2:0] are unused.
- Standard frames: only word1[15:5] vs rx_id[28:18] are compared; word2 is never examined.
- Match per word: ((id_bits XOR code_bits) AND mask_bits) == 0 over the relevant bits.
- FSM states: IDLE, CMP1, CMP2, RESULT.
- IDLE: on id_valid=1, latch rx_id, rx_ide, filt_en, code1/2 and mask1/2 into snapshot registers -> CMP1.
- Later CPU writes to code/mask do not affect the frame in progress.
- CMP1:
  - if snapshot filt_en=0 -> RESULT with verdict accept;
  - else word1 mismatch -> RESULT reject;
  - word1 match and ide=0 -> RESULT accept;
  - word1 match and ide=1 -> CMP2.
- CMP2: word2 match -> RESULT accept, else RESULT reject.
- RESULT: accept or reject (exactly one) high for this cycle only -> IDLE.
- busy = 1 in CMP1, CMP2 and RESULT; 0 in IDLE.
- Latency, edge E = edge sampling id_valid:
  - CMP1 decision: pulse during cycle after E+1 (visible after edge E+2);
  - extended frame through CMP2: pulse one cycle later (after edge E+3).
- accept and reject are never high simultaneously; each is high for exactly one clock per identifier.
- Back-to-back: id_valid in the RESULT cycle is not accepted (busy=1).
  - Next identifier may be presented in the first IDLE cycle.
  - Max throughput: one identifier per 3 clocks (standard) or 4 clocks (extended).
- Overrun: id_valid=1 while busy=1 -> identifier dropped, overrun set next edge, current compare undisturbed.
- overrun clears only on ovr_clr=1; if ovr_clr and a new overrun event coincide, the set wins.
- Reset mid-compare: immediate return to IDLE with no accept/reject pulse; the dropped frame is not reported.
- mask=0x0000 on both words: every identifier is accepted.

Test Plan:
- Reset check: rst=0 asynchronously mid-CMP2 -> busy/accept/reject/overrun = 0 immediately; no pulse after rst released.
- Standard accept: code1=0x2460, mask1=0xFFE0, rx_ide=0, rx_id[28:18]=0x123 -> accept pulse at E+2, busy 2 cycles before it, reject stays 0.
- Standard don't-care: same code, rx_id[28:18]=0x122 with mask1=0xFFE0 -> reject at E+2; repeat with mask1=0xFFC0 -> accept.
- Extended accept/reject via word2: code1=0xABCD, mask1=0xFFFF, code2=0x1238, mask2=0xFFF8, rx_ide=1, rx_id={0xABCD,13'h0247} -> accept at E+3.
  - Change rx_id[0] -> reject at E+3.
  - Word1 mismatch -> reject at E+2, CMP2 never entered.
- Snapshot/filter disable: filt_en=0, any ID -> accept at E+2.
  - With filt_en=1, write code1 one cycle after id_valid -> result reflects old code1.
- Overrun: id_valid again one cycle after first -> first result unchanged, overrun=1 sticky.
  - ovr_clr=1 -> overrun=0.
  - ovr_clr concurrent with a new overrun -> overrun stays 1.
